// File: rtl/imem_loader_if.sv
// Interface bundling the load request, byte stream, instruction-memory write
// port and CPU status lines of the instruction-memory loader.
interface imem_loader_if #(
   parameter int ADDR_W = 29
);
   logic              start;
   logic [10:0]       word_count;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;
   logic              cpu_hold;
   logic              done;
   logic              err;

   modport master (
      output start, word_count, in_valid, in_data,
      input  in_ready, we, waddr, wdata, cpu_hold, done, err
   );

   modport slave (
      input  start, word_count, in_valid, in_data,
      output in_ready, we, waddr, wdata, cpu_hold, done, err
   );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs an MSB-first byte stream into 32-bit words,
// writes them to consecutive word addresses and holds the CPU until done.
//
// state | meaning
// IDLE  | after reset, waiting for start; CPU held
// LOAD  | accepting bytes of the current word
// WRITE | one-cycle write strobe of the assembled word
// DONE  | load finished (or rejected); CPU released, start reloads
module imem_loader #(
   parameter int ROM_SIZE = 1024,
   parameter int ADDR_W   = 29
) (
   input  logic          clk,
   input  logic          rst_n,
   imem_loader_if.slave  bus
);
   localparam int          CNT_W      = (ROM_SIZE > 1) ? $clog2(ROM_SIZE) : 1;
   localparam logic [11:0] ROM_SIZE_L = 12'(ROM_SIZE);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   state_t             state_q, state_d;
   logic [10:0]        cnt_q, cnt_d;
   logic [CNT_W-1:0]   widx_q, widx_d;
   logic [CNT_W-1:0]   waddr_q, waddr_d;
   logic [1:0]         byte_cnt_q, byte_cnt_d;
   logic [23:0]        word_q, word_d;
   logic [31:0]        wdata_q, wdata_d;
   logic               err_q, err_d;
   logic [10:0]        written;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         widx_q     <= '0;
         waddr_q    <= '0;
         byte_cnt_q <= '0;
         word_q     <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         widx_q     <= widx_d;
         waddr_q    <= waddr_d;
         byte_cnt_q <= byte_cnt_d;
         word_q     <= word_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      widx_d     = widx_q;
      waddr_d    = waddr_q;
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      written    = 11'(widx_q) + 11'd1;

      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               if (bus.word_count == 11'd0) begin
                  state_d = DONE;
                  err_d   = 1'b0;
               end else if ({1'b0, bus.word_count} > ROM_SIZE_L) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d    = LOAD;
                  cnt_d      = bus.word_count;
                  widx_d     = '0;
                  byte_cnt_d = '0;
                  err_d      = 1'b0;
               end
            end
         end
         LOAD: begin
            if (bus.in_valid) begin
               word_d     = {word_q[15:0], bus.in_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
               // The fourth byte goes straight into the output register so the
               // assembly register is free for the next word.
               if (byte_cnt_q == 2'd3) begin
                  state_d = WRITE;
                  wdata_d = {word_q, bus.in_data};
                  waddr_d = widx_q;
               end
            end
         end
         WRITE: begin
            if (written == cnt_q) begin
               state_d = DONE;
            end else begin
               widx_d  = widx_q + 1'b1;
               state_d = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready = (state_q == LOAD);
   assign bus.we       = (state_q == WRITE);
   assign bus.waddr    = ADDR_W'(waddr_q);
   assign bus.wdata    = wdata_q;
   assign bus.cpu_hold = (state_q != DONE);
   assign bus.done     = (state_q == DONE);
   assign bus.err      = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: each task drives one scenario and checks
// the write log captured by the monitor against hand-computed values.
module tb_imem_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(29)) bus();
   imem_loader #(.ROM_SIZE(1024), .ADDR_W(29)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [28:0] wa_q[$];
   logic [31:0] wd_q[$];
   int ready_cnt = 0;

   always @(negedge clk) begin
      if (bus.we === 1'b1) begin
         wa_q.push_back(bus.waddr);
         wd_q.push_back(bus.wdata);
      end
      if (bus.in_ready === 1'b1) ready_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [10:0] wc);
      bus.start      = 1'b1;
      bus.word_count = wc;
      tick();
      bus.start      = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL send_byte_timeout: in_ready=%b want 1 (byte %h)", bus.in_ready, b);
      end
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (bus.done !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      vectors++;
      if (bus.done !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_done_timeout: done=%b want 1", name, bus.done);
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.word_count = '0; bus.in_valid = 1'b0; bus.in_data = '0;
      #2 rst_n = 1'b0;
      tick(); tick();
      vectors += 7;
      if (bus.cpu_hold !== 1'b1) begin miscompares++; $display("FAIL rst_cpu_hold: got %b want 1", bus.cpu_hold); end
      if (bus.done !== 1'b0)     begin miscompares++; $display("FAIL rst_done: got %b want 0", bus.done); end
      if (bus.err !== 1'b0)      begin miscompares++; $display("FAIL rst_err: got %b want 0", bus.err); end
      if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
      if (bus.we !== 1'b0)       begin miscompares++; $display("FAIL rst_we: got %b want 0", bus.we); end
      if (bus.waddr !== 29'd0)   begin miscompares++; $display("FAIL rst_waddr: got %h want 0", bus.waddr); end
      if (bus.wdata !== 32'd0)   begin miscompares++; $display("FAIL rst_wdata: got %h want 0", bus.wdata); end
      rst_n = 1'b1;
      tick();
      vectors += 2;
      if (bus.in_ready !== 1'b0 || bus.we !== 1'b0) begin
         miscompares++; $display("FAIL idle_outputs: in_ready=%b we=%b want 0 0", bus.in_ready, bus.we);
      end
      if (bus.cpu_hold !== 1'b1) begin miscompares++; $display("FAIL idle_cpu_hold: got %b want 1", bus.cpu_hold); end
   endtask

   task automatic test_zero_count();
      int m = wa_q.size();
      do_start(11'd0);
      vectors += 4;
      if (bus.done !== 1'b1)     begin miscompares++; $display("FAIL zero_done: got %b want 1", bus.done); end
      if (bus.err !== 1'b0)      begin miscompares++; $display("FAIL zero_err: got %b want 0", bus.err); end
      if (bus.cpu_hold !== 1'b0) begin miscompares++; $display("FAIL zero_cpu_hold: got %b want 0", bus.cpu_hold); end
      tick(); tick();
      if (wa_q.size() != m)      begin miscompares++; $display("FAIL zero_writes: got %0d want 0", wa_q.size() - m); end
   endtask

   task automatic test_two_words();
      logic [7:0] b [8] = '{8'h20, 8'h10, 8'h00, 8'h14, 8'h20, 8'h05, 8'h00, 8'h00};
      int m = wa_q.size();
      do_start(11'd2);
      vectors += 2;
      if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL two_in_ready: got %b want 1", bus.in_ready); end
      if (bus.done !== 1'b0 || bus.cpu_hold !== 1'b1) begin
         miscompares++; $display("FAIL two_load_status: done=%b cpu_hold=%b want 0 1", bus.done, bus.cpu_hold);
      end
      for (int i = 0; i < 8; i++) begin
         send_byte(b[i]);
         if (i == 3) begin
            vectors += 2;
            if (bus.we !== 1'b1 || bus.in_ready !== 1'b0) begin
               miscompares++; $display("FAIL two_we_latency: we=%b in_ready=%b want 1 0", bus.we, bus.in_ready);
            end
            if (bus.waddr !== 29'd0 || bus.wdata !== 32'h20100014) begin
               miscompares++; $display("FAIL two_first_word: got %h/%h want 0/20100014", bus.waddr, bus.wdata);
            end
         end
      end
      wait_done("two");
      vectors += 2;
      if (wa_q.size() - m != 2) begin
         miscompares++; $display("FAIL two_write_count: got %0d want 2", wa_q.size() - m);
      end else begin
         vectors += 2;
         if (wa_q[m] !== 29'd0 || wd_q[m] !== 32'h20100014) begin
            miscompares++; $display("FAIL two_w0: got %h/%h want 0/20100014", wa_q[m], wd_q[m]);
         end
         if (wa_q[m+1] !== 29'd1 || wd_q[m+1] !== 32'h20050000) begin
            miscompares++; $display("FAIL two_w1: got %h/%h want 1/20050000", wa_q[m+1], wd_q[m+1]);
         end
      end
      if (bus.cpu_hold !== 1'b0 || bus.err !== 1'b0) begin
         miscompares++; $display("FAIL two_final: cpu_hold=%b err=%b want 0 0", bus.cpu_hold, bus.err);
      end
   endtask

   task automatic test_gaps();
      logic [7:0] b [4] = '{8'h01, 8'h24, 8'h50, 8'h20};
      int m = wa_q.size();
      do_start(11'd1);
      for (int i = 0; i < 4; i++) begin
         send_byte(b[i]);
         repeat (3) tick();
      end
      wait_done("gaps");
      vectors++;
      if (wa_q.size() - m != 1) begin
         miscompares++; $display("FAIL gaps_write_count: got %0d want 1", wa_q.size() - m);
      end else begin
         vectors++;
         if (wa_q[m] !== 29'd0 || wd_q[m] !== 32'h01245020) begin
            miscompares++; $display("FAIL gaps_word: got %h/%h want 0/01245020", wa_q[m], wd_q[m]);
         end
      end
   endtask

   task automatic test_overflow();
      int m = wa_q.size();
      int r;
      do_start(11'd1025);
      r = ready_cnt;
      vectors += 2;
      if (bus.done !== 1'b1 || bus.err !== 1'b1) begin
         miscompares++; $display("FAIL ovf_status: done=%b err=%b want 1 1", bus.done, bus.err);
      end
      if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL ovf_in_ready: got %b want 0", bus.in_ready); end
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h5a;
      repeat (5) tick();
      vectors += 3;
      if (ready_cnt != r)        begin miscompares++; $display("FAIL ovf_ready_seen: got %0d want 0", ready_cnt - r); end
      if (wa_q.size() != m)      begin miscompares++; $display("FAIL ovf_writes: got %0d want 0", wa_q.size() - m); end
      if (bus.err !== 1'b1)      begin miscompares++; $display("FAIL ovf_err_level: got %b want 1", bus.err); end
   endtask

   task automatic test_reload_after_err();
      int m = wa_q.size();
      do_start(11'd1);
      bus.in_valid = 1'b0;
      vectors += 2;
      if (bus.err !== 1'b0 || bus.done !== 1'b0) begin
         miscompares++; $display("FAIL reload_clear: err=%b done=%b want 0 0", bus.err, bus.done);
      end
      if (bus.cpu_hold !== 1'b1) begin miscompares++; $display("FAIL reload_cpu_hold: got %b want 1", bus.cpu_hold); end
      send_byte(8'hde); send_byte(8'had); send_byte(8'hbe); send_byte(8'hef);
      wait_done("reload");
      vectors++;
      if (wa_q.size() - m != 1) begin
         miscompares++; $display("FAIL reload_write_count: got %0d want 1", wa_q.size() - m);
      end else begin
         vectors++;
         if (wa_q[m] !== 29'd0 || wd_q[m] !== 32'hdeadbeef) begin
            miscompares++; $display("FAIL reload_word: got %h/%h want 0/deadbeef", wa_q[m], wd_q[m]);
         end
      end
   endtask

   task automatic test_reset_mid_load();
      int m = wa_q.size();
      do_start(11'd1);
      send_byte(8'haa);
      send_byte(8'hbb);
      rst_n = 1'b0;
      #1;
      vectors += 3;
      if (bus.we !== 1'b0 || bus.in_ready !== 1'b0) begin
         miscompares++; $display("FAIL rmid_outputs: we=%b in_ready=%b want 0 0", bus.we, bus.in_ready);
      end
      if (bus.cpu_hold !== 1'b1 || bus.done !== 1'b0) begin
         miscompares++; $display("FAIL rmid_status: cpu_hold=%b done=%b want 1 0", bus.cpu_hold, bus.done);
      end
      if (bus.wdata !== 32'd0) begin miscompares++; $display("FAIL rmid_wdata: got %h want 0", bus.wdata); end
      tick(); tick();
      rst_n = 1'b1;
      tick();
      vectors++;
      if (wa_q.size() != m || bus.we !== 1'b0) begin
         miscompares++; $display("FAIL rmid_no_write: writes=%0d we=%b want 0 0", wa_q.size() - m, bus.we);
      end
      do_start(11'd1);
      send_byte(8'h14); send_byte(8'h90); send_byte(8'hff); send_byte(8'hf6);
      wait_done("rmid");
      vectors++;
      if (wa_q.size() - m != 1) begin
         miscompares++; $display("FAIL rmid_write_count: got %0d want 1", wa_q.size() - m);
      end else begin
         vectors++;
         if (wa_q[m] !== 29'd0 || wd_q[m] !== 32'h1490fff6) begin
            miscompares++; $display("FAIL rmid_word: got %h/%h want 0/1490fff6", wa_q[m], wd_q[m]);
         end
      end
   endtask

   task automatic test_full_rom();
      int m = wa_q.size();
      logic [7:0] bv;
      do_start(11'd1024);
      for (int w = 0; w < 1024; w++) begin
         bv = 8'(w);
         for (int k = 0; k < 4; k++) begin
            send_byte(bv);
            if ((w == 500 && k == 3) || (w == 600 && k == 1)) begin
               do_start(11'd3);
            end
         end
      end
      wait_done("full");
      vectors++;
      if (wa_q.size() - m != 1024) begin
         miscompares++; $display("FAIL full_write_count: got %0d want 1024", wa_q.size() - m);
      end else begin
         for (int i = 0; i < 1024; i++) begin
            bv = 8'(i);
            vectors++;
            if (wa_q[m+i] !== 29'(i) || wd_q[m+i] !== {bv, bv, bv, bv}) begin
               miscompares++;
               $display("FAIL full_word_%0d: got %h/%h want %h/%h", i, wa_q[m+i], wd_q[m+i], 29'(i), {bv, bv, bv, bv});
            end
         end
      end
      tick();
      vectors += 2;
      if (bus.waddr !== 29'd1023 || bus.wdata !== 32'hffffffff) begin
         miscompares++; $display("FAIL full_hold_last: got %h/%h want 3ff/ffffffff", bus.waddr, bus.wdata);
      end
      if (bus.cpu_hold !== 1'b0 || bus.err !== 1'b0) begin
         miscompares++; $display("FAIL full_final: cpu_hold=%b err=%b want 0 0", bus.cpu_hold, bus.err);
      end
   endtask

   initial begin
      test_reset();
      test_zero_count();
      test_two_words();
      test_gaps();
      test_overflow();
      test_reload_after_err();
      test_reset_mid_load();
      test_full_rom();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
